// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub for the CPU's top 1 KiB window.
// Provides debounced switch inputs, byte-writable LED outputs and a compare-match cycle timer.
`timescale 1ns/1ps

module mmio_io_hub #(
    parameter int N_SW       = 1,
    parameter int N_LED      = 1,
    parameter int CH_W       = 16,
    parameter int DEB_CYCLES = 4,
    parameter int TIMER_W    = 32
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    io_read,
    input  logic                    io_write,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    input  logic [3:0]              wr_be,
    output logic [31:0]             rdata,
    output logic                    io_sel,
    input  logic [N_SW*CH_W-1:0]    sw_in,
    output logic [N_LED*CH_W-1:0]   led_out,
    output logic                    irq
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    function automatic logic [CH_W-1:0] merge_ch(input logic [CH_W-1:0] old_val,
                                                 input logic [31:0] data,
                                                 input logic [3:0] be);
        logic [CH_W-1:0] res;
        for (int b = 0; b < CH_W; b++) begin
            res[b] = be[b/8] ? data[b] : old_val[b];
        end
        return res;
    endfunction

    function automatic logic [TIMER_W-1:0] merge_tmr(input logic [TIMER_W-1:0] old_val,
                                                     input logic [31:0] data,
                                                     input logic [3:0] be);
        logic [TIMER_W-1:0] res;
        for (int b = 0; b < TIMER_W; b++) begin
            res[b] = be[b/8] ? data[b] : old_val[b];
        end
        return res;
    endfunction

    logic [9:0]  offset;
    logic [5:0]  idx;
    logic        wr_en;
    logic        led_region;
    logic        sw_region;
    logic        tmr_region;
    logic        wr_ctrl;
    logic        wr_cmp;
    logic        wr_status;
    logic        unused_bits;

    assign offset     = addr[9:0];
    assign idx        = offset[7:2];
    assign io_sel     = (addr[31:10] == 22'h3FFFFF);
    assign wr_en      = io_write & io_sel;
    assign led_region = (offset[9:8] == 2'b00);
    assign sw_region  = (offset[9:8] == 2'b01);
    assign tmr_region = (offset[9:4] == 6'h20);
    assign wr_ctrl    = wr_en & tmr_region & (offset[3:2] == 2'd0);
    assign wr_cmp     = wr_en & tmr_region & (offset[3:2] == 2'd2);
    assign wr_status  = wr_en & tmr_region & (offset[3:2] == 2'd3);
    assign unused_bits = ^{addr[1:0], wdata};

    logic [CH_W-1:0] led_q [N_LED];

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < N_LED; i++) led_q[i] <= '0;
        end else if (wr_en && led_region) begin
            for (int i = 0; i < N_LED; i++) begin
                if (idx == 6'(i)) led_q[i] <= merge_ch(led_q[i], wdata, wr_be);
            end
        end
    end

    for (genvar g = 0; g < N_LED; g++) begin : g_led
        assign led_out[g*CH_W +: CH_W] = led_q[g];
    end

    logic [CH_W-1:0]  sw_s1  [N_SW];
    logic [CH_W-1:0]  sw_s2  [N_SW];
    logic [CH_W-1:0]  sw_deb [N_SW];
    logic [CNT_W-1:0] sw_cnt [N_SW];

    // Stability is judged on the word entering the last sync stage, so a change
    // held steady becomes readable exactly DEB_CYCLES cycles after it is synchronized.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < N_SW; i++) begin
                sw_s1[i]  <= '0;
                sw_s2[i]  <= '0;
                sw_deb[i] <= '0;
                sw_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                sw_s1[i] <= sw_in[i*CH_W +: CH_W];
                sw_s2[i] <= sw_s1[i];
                if (sw_s1[i] != sw_s2[i]) begin
                    sw_cnt[i] <= '0;
                end else if ((sw_s2[i] != sw_deb[i]) && (sw_cnt[i] == CNT_LAST)) begin
                    sw_deb[i] <= sw_s2[i];
                    sw_cnt[i] <= '0;
                end else if (sw_cnt[i] != CNT_MAX) begin
                    sw_cnt[i] <= sw_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    logic [1:0]         ctrl;
    logic [TIMER_W-1:0] count;
    logic [TIMER_W-1:0] cmp;
    logic               status;

    // Later assignments win: count clear beats increment, match set beats W1C.
    always_ff @(posedge clock) begin
        if (rst) begin
            ctrl   <= '0;
            count  <= '0;
            cmp    <= '0;
            status <= 1'b0;
        end else begin
            if (ctrl[0]) count <= count + TIMER_W'(1);
            if (wr_ctrl && wr_be[0] && wdata[2]) count <= '0;
            if (wr_ctrl && wr_be[0]) ctrl <= wdata[1:0];
            if (wr_cmp) cmp <= merge_tmr(cmp, wdata, wr_be);
            if (wr_status && wr_be[0] && wdata[0]) status <= 1'b0;
            if (ctrl[0] && (count == cmp)) status <= 1'b1;
        end
    end

    assign irq = status & ctrl[1];

    always_comb begin
        rdata = '0;
        if (io_read && io_sel) begin
            if (led_region) begin
                for (int i = 0; i < N_LED; i++) begin
                    if (idx == 6'(i)) rdata = 32'(led_q[i]);
                end
            end else if (sw_region) begin
                for (int i = 0; i < N_SW; i++) begin
                    if (idx == 6'(i)) rdata = 32'(sw_deb[i]);
                end
            end else if (tmr_region) begin
                case (offset[3:2])
                    2'd0:    rdata = {30'b0, ctrl};
                    2'd1:    rdata = 32'(count);
                    2'd2:    rdata = 32'(cmp);
                    default: rdata = {31'b0, status};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed bench for mmio_io_hub: reset, LED byte enables, debounce, timer/irq, wrap and decode.
`timescale 1ns/1ps

module tb_mmio_io_hub;

    localparam int N_SW       = 2;
    localparam int N_LED      = 2;
    localparam int CH_W       = 16;
    localparam int DEB_CYCLES = 4;
    localparam int TIMER_W    = 4;

    localparam logic [31:0] A_LED0   = 32'hFFFF_FC00;
    localparam logic [31:0] A_LED1   = 32'hFFFF_FC04;
    localparam logic [31:0] A_LED2   = 32'hFFFF_FC08;
    localparam logic [31:0] A_SW0    = 32'hFFFF_FD00;
    localparam logic [31:0] A_SW1    = 32'hFFFF_FD04;
    localparam logic [31:0] A_CTRL   = 32'hFFFF_FE00;
    localparam logic [31:0] A_COUNT  = 32'hFFFF_FE04;
    localparam logic [31:0] A_CMP    = 32'hFFFF_FE08;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FE0C;

    logic                  clock = 1'b0;
    logic                  rst;
    logic                  io_read;
    logic                  io_write;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [3:0]            wr_be;
    logic [31:0]           rdata;
    logic                  io_sel;
    logic [N_SW*CH_W-1:0]  sw_in;
    logic [N_LED*CH_W-1:0] led_out;
    logic                  irq;

    int checks = 0;
    int errors = 0;

    mmio_io_hub #(
        .N_SW(N_SW), .N_LED(N_LED), .CH_W(CH_W),
        .DEB_CYCLES(DEB_CYCLES), .TIMER_W(TIMER_W)
    ) dut (
        .clock(clock), .rst(rst), .io_read(io_read), .io_write(io_write),
        .addr(addr), .wdata(wdata), .wr_be(wr_be), .rdata(rdata),
        .io_sel(io_sel), .sw_in(sw_in), .led_out(led_out), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] be);
        io_write = 1'b1;
        addr     = a;
        wdata    = d;
        wr_be    = be;
        tick();
        io_write = 1'b0;
        wdata    = '0;
        wr_be    = '0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a,
                              input logic [31:0] expected);
        io_read = 1'b1;
        addr    = a;
        #1;
        check_output(tag, rdata, expected);
        io_read = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        io_read  = 1'b0;
        io_write = 1'b1;
        addr     = A_LED0;
        wdata    = 32'h0000_FFFF;
        wr_be    = 4'hF;
        sw_in    = '0;
        tick();
        rst      = 1'b0;
        io_write = 1'b0;
        $display("[TB] reset");
        check_output("rst_led", led_out, 32'h0);
        check_output("rst_irq", 32'(irq), 32'h0);
        read_check("rst_led0", A_LED0, 32'h0);
        read_check("rst_ctrl", A_CTRL, 32'h0);
        read_check("rst_count", A_COUNT, 32'h0);
        read_check("rst_status", A_STATUS, 32'h0);
        read_check("rst_sw0", A_SW0, 32'h0);

        $display("[TB] LED byte enables");
        apply_stimulus(A_LED1, 32'h0000_1234, 4'b0011);
        check_output("led1_full", led_out, 32'h1234_0000);
        apply_stimulus(A_LED1, 32'h0000_AB00, 4'b0010);
        check_output("led1_be", led_out, 32'hAB34_0000);
        apply_stimulus(A_LED2, 32'h0000_FFFF, 4'hF);
        check_output("led_oob_write", led_out, 32'hAB34_0000);
        read_check("led1_read", A_LED1, 32'h0000_AB34);
        read_check("led_oob_read", A_LED2, 32'h0);
        apply_stimulus(A_LED0, 32'hDEAD_BEEF, 4'hF);
        check_output("led0_trunc", led_out, 32'hAB34_BEEF);
        io_write = 1'b1;
        io_read  = 1'b1;
        addr     = A_LED0;
        wdata    = 32'h0000_5555;
        wr_be    = 4'hF;
        #1;
        check_output("rd_during_wr", rdata, 32'h0000_BEEF);
        tick();
        io_write = 1'b0;
        io_read  = 1'b0;
        check_output("wr_after_rd", led_out, 32'hAB34_5555);

        $display("[TB] debounce");
        tick();
        sw_in[15:0] = 16'h00FF;
        for (int k = 1; k <= 6; k++) begin
            tick();
            read_check($sformatf("deb_cyc%0d", k), A_SW0, (k >= 6) ? 32'h00FF : 32'h0);
        end
        tick();
        sw_in[31:16] = 16'h0F0F;
        repeat (3) tick();
        sw_in[31:16] = 16'h0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            read_check($sformatf("glitch_cyc%0d", k), A_SW1, 32'h0);
        end
        read_check("deb_hold", A_SW0, 32'h00FF);

        $display("[TB] timer and irq");
        apply_stimulus(A_CMP, 32'h0000_0005, 4'hF);
        apply_stimulus(A_CTRL, 32'h0000_0003, 4'hF);
        for (int j = 1; j <= 6; j++) begin
            tick();
            read_check($sformatf("count_%0d", j), A_COUNT, 32'(j));
            check_output($sformatf("irq_%0d", j), 32'(irq), (j >= 6) ? 32'h1 : 32'h0);
        end
        read_check("status_set", A_STATUS, 32'h1);
        apply_stimulus(A_STATUS, 32'h0000_0001, 4'b0001);
        check_output("irq_w1c", 32'(irq), 32'h0);
        read_check("status_w1c", A_STATUS, 32'h0);
        read_check("count_7", A_COUNT, 32'h7);
        repeat (14) tick();
        read_check("count_5_again", A_COUNT, 32'h5);
        check_output("irq_pre_match", 32'(irq), 32'h0);
        apply_stimulus(A_STATUS, 32'h0000_0001, 4'b0001);
        check_output("irq_set_wins", 32'(irq), 32'h1);
        read_check("status_set_wins", A_STATUS, 32'h1);

        $display("[TB] wrap and clear");
        repeat (9) tick();
        read_check("count_15", A_COUNT, 32'hF);
        tick();
        read_check("count_wrap", A_COUNT, 32'h0);
        repeat (3) tick();
        read_check("count_3", A_COUNT, 32'h3);
        apply_stimulus(A_CTRL, 32'h0000_0005, 4'hF);
        read_check("count_clear", A_COUNT, 32'h0);
        read_check("ctrl_read", A_CTRL, 32'h1);
        check_output("irq_disabled", 32'(irq), 32'h0);
        tick();
        read_check("count_resume", A_COUNT, 32'h1);

        $display("[TB] decode");
        io_read = 1'b1;
        addr    = 32'hFFFF_FBFC;
        #1;
        check_output("sel_outside", 32'(io_sel), 32'h0);
        check_output("rdata_outside", rdata, 32'h0);
        addr = A_LED0;
        #1;
        check_output("sel_inside", 32'(io_sel), 32'h1);
        io_read = 1'b0;
        #1;
        check_output("rdata_no_read", rdata, 32'h0);
        read_check("unmapped_210", 32'hFFFF_FE10, 32'h0);

        $display("[TB] reset over write");
        rst      = 1'b1;
        io_write = 1'b1;
        addr     = A_LED0;
        wdata    = 32'h0000_FFFF;
        wr_be    = 4'hF;
        tick();
        rst      = 1'b0;
        io_write = 1'b0;
        check_output("rst2_led", led_out, 32'h0);
        check_output("rst2_irq", 32'(irq), 32'h0);
        read_check("rst2_count", A_COUNT, 32'h0);
        read_check("rst2_sw0", A_SW0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
